// File: rtl/conv_output_buffer.sv
// conv_output_buffer
//   Frame buffer between two convolution layers. Each upstream beat carries
//   one output row (N_CHANNELS words). Once FRAME_HEIGHT rows are held, the
//   downstream layer is started and the frame is streamed to it one word at a
//   time. The order is row-major with channels interleaved:
//   r0c0, r0c1 .. r0c(N-1), r1c0 ...
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       asynchronous, active-low reset
//   valid_i       upstream beat valid
//   ready_o       buffer can accept a beat (eFILL only)
//   data_i        beat; channel k is data_i[k*WORD_SIZE +: WORD_SIZE]
//   next_ready_i  downstream layer is idle
//   start_o       one-cycle start pulse to the downstream layer
//   valid_o       downstream word valid (eDRAIN only)
//   yumi_i        downstream consumes the current word
//   data_o        downstream word (zero outside eDRAIN)
module conv_output_buffer #(
    parameter int WORD_SIZE    = 16,
    parameter int N_CHANNELS   = 2,
    parameter int FRAME_HEIGHT = 3
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [N_CHANNELS*WORD_SIZE-1:0] data_i,
    input  logic                            next_ready_i,
    output logic                            start_o,
    output logic                            valid_o,
    input  logic                            yumi_i,
    output logic [WORD_SIZE-1:0]            data_o
);

    localparam int ROW_W  = $clog2(FRAME_HEIGHT + 1);
    localparam int CH_W   = $clog2(N_CHANNELS + 1);
    // Index widths that exactly address the storage arrays.
    localparam int RIDX_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int CIDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CHANNELS - 1);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);

    typedef enum logic [1:0] {
        eFILL  = 2'd0,
        eSTART = 2'd1,
        eDRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              wr_en;
    logic              accept;

    // One packed beat per row; contents need no reset.
    logic [N_CHANNELS*WORD_SIZE-1:0] row_mem [FRAME_HEIGHT];
    logic [WORD_SIZE-1:0]            ch_words [N_CHANNELS];
    logic [RIDX_W-1:0]               row_idx;
    logic [CIDX_W-1:0]               ch_idx;

    assign row_idx = row_q[RIDX_W-1:0];
    assign ch_idx  = ch_q[CIDX_W-1:0];

    // Outputs come from registered state only (plus the start request).
    // ready_o is also held low while reset is asserted so nothing upstream
    // sees a ready buffer before the first clocked cycle.
    assign ready_o = reset_i && (state_q == eFILL);
    assign start_o = (state_q == eSTART) && next_ready_i;
    assign valid_o = (state_q == eDRAIN);
    assign accept  = valid_i && ready_o;

    // Split the currently addressed row into its channel words.
    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_unpack
            assign ch_words[gi] = row_mem[row_idx][gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    assign data_o = valid_o ? ch_words[ch_idx] : '0;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        ch_d    = ch_q;
        wr_en   = 1'b0;
        unique case (state_q)
            eFILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = eSTART;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end
            end
            eSTART: begin
                if (next_ready_i) begin
                    state_d = eDRAIN;
                end
            end
            eDRAIN: begin
                if (yumi_i) begin
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = eFILL;
                        end else begin
                            row_d = row_q + ROW_ONE;
                        end
                    end else begin
                        ch_d = ch_q + CH_ONE;
                    end
                end
            end
            default: begin
                state_d = eFILL;
                row_d   = '0;
                ch_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= eFILL;
            row_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            row_mem[row_idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_conv_output_buffer.sv
module tb_conv_output_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WORD_SIZE=16, N_CHANNELS=2, FRAME_HEIGHT=3
    logic        reset_i;
    logic        valid_i, ready_o, next_ready_i, start_o, valid_o, yumi_i;
    logic [31:0] data_i;
    logic [15:0] data_o;

    conv_output_buffer #(.WORD_SIZE(16), .N_CHANNELS(2), .FRAME_HEIGHT(3)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .next_ready_i(next_ready_i), .start_o(start_o),
        .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o)
    );

    // Second instance: N_CHANNELS=1, FRAME_HEIGHT=1
    logic        v2, r2, nr2, s2, vo2, y2;
    logic [15:0] d2, do2;

    conv_output_buffer #(.WORD_SIZE(16), .N_CHANNELS(1), .FRAME_HEIGHT(1)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .valid_i(v2), .ready_o(r2),
        .data_i(d2), .next_ready_i(nr2), .start_o(s2),
        .valid_o(vo2), .yumi_i(y2), .data_o(do2)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        nr;
        logic        y;
        logic        er;
        logic        es;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle on the main instance: drive inputs, compare outputs at
    // the falling edge, then advance past the rising edge.
    task automatic step(input string tag, input vec_t t);
        valid_i      = t.v;
        data_i       = t.d;
        next_ready_i = t.nr;
        yumi_i       = t.y;
        @(negedge clk);
        $display("[TB] %s v=%0b d=%h nr=%0b y=%0b -> rdy=%0b st=%0b vld=%0b dat=%h",
                 tag, t.v, t.d, t.nr, t.y, ready_o, start_o, valid_o, data_o);
        chk({tag, " ready_o"}, 32'(ready_o), 32'(t.er));
        chk({tag, " start_o"}, 32'(start_o), 32'(t.es));
        chk({tag, " valid_o"}, 32'(valid_o), 32'(t.ev));
        chk({tag, " data_o"},  32'(data_o),  32'(t.ed));
        @(posedge clk);
        #1;
    endtask

    // One clock cycle on the N_CHANNELS=1 / FRAME_HEIGHT=1 instance.
    task automatic step2(input string tag, input logic v, input logic [15:0] d,
                         input logic nr, input logic y, input logic er,
                         input logic es, input logic ev, input logic [15:0] ed);
        v2 = v; d2 = d; nr2 = nr; y2 = y;
        @(negedge clk);
        $display("[TB] %s v=%0b d=%h nr=%0b y=%0b -> rdy=%0b st=%0b vld=%0b dat=%h",
                 tag, v, d, nr, y, r2, s2, vo2, do2);
        chk({tag, " ready_o"}, 32'(r2),  32'(er));
        chk({tag, " start_o"}, 32'(s2),  32'(es));
        chk({tag, " valid_o"}, 32'(vo2), 32'(ev));
        chk({tag, " data_o"},  32'(do2), 32'(ed));
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        vec_t t;

        // ------------------------------------------------------------
        // Vector table. Fields: v, d, nr, y | ready, start, valid, data
        // ------------------------------------------------------------
        // Basic frame, words 1..6, continuous consume
        vq.push_back('{1'b1, 32'h0002_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 32'h0004_0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 32'h0006_0005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        for (int k = 1; k <= 6; k++)
            vq.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'(k)});
        vq.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        // Frame 0x11..0x16 with yumi_i asserted illegally during fill
        vq.push_back('{1'b1, 32'h0012_0011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 32'h0014_0013, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 32'h0016_0015, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        // Delayed start: downstream busy for 5 cycles, junk beats and yumi ignored
        for (int k = 0; k < 5; k++)
            vq.push_back('{1'b1, JUNK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        // Drain with stalls (yumi 1,0,0,1) and junk beats offered
        vq.push_back('{1'b1, JUNK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0011});
        vq.push_back('{1'b1, JUNK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0012});
        vq.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0012});
        vq.push_back('{1'b1, JUNK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0012});
        vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0013});
        vq.push_back('{1'b1, JUNK, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0014});
        vq.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0015});
        // Last yumi: a beat offered in the same cycle must not be taken
        vq.push_back('{1'b1, JUNK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0016});
        // Back in fill: frame 0x21..0x26 streamed straight through
        vq.push_back('{1'b1, 32'h0022_0021, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 32'h0024_0023, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 32'h0026_0025, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vq.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        for (int k = 0; k < 6; k++)
            vq.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'(32'h21 + k)});
        vq.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});

        // ------------------------------------------------------------
        // Reset state
        // ------------------------------------------------------------
        reset_i = 1'b0;
        valid_i = 1'b0; data_i = '0; next_ready_i = 1'b0; yumi_i = 1'b0;
        v2 = 1'b0; d2 = '0; nr2 = 1'b0; y2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready_o", 32'(ready_o), 32'd0);
        chk("reset start_o", 32'(start_o), 32'd0);
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset data_o",  32'(data_o),  32'd0);
        @(posedge clk);
        #1 reset_i = 1'b1;

        // ------------------------------------------------------------
        // Table-driven vectors
        // ------------------------------------------------------------
        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("vec%0d", i), vq[i]);
        end

        // ------------------------------------------------------------
        // Reset in the middle of a frame
        // ------------------------------------------------------------
        step("rst beat0", '{1'b1, 32'h0032_0031, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        step("rst beat1", '{1'b1, 32'h0034_0033, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        valid_i = 1'b1; data_i = JUNK; next_ready_i = 1'b1; yumi_i = 1'b1;
        reset_i = 1'b0;
        #1;
        chk("midrst ready_o", 32'(ready_o), 32'd0);
        chk("midrst start_o", 32'(start_o), 32'd0);
        chk("midrst valid_o", 32'(valid_o), 32'd0);
        chk("midrst data_o",  32'(data_o),  32'd0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        // Two beats after reset must not complete the frame.
        step("post beat0", '{1'b1, 32'h000B_000A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        step("post beat1", '{1'b1, 32'h000D_000C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        step("post beat2", '{1'b1, 32'h000F_000E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
        step("post start", '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
        for (int k = 0; k < 6; k++) begin
            t = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'(32'hA + k)};
            step($sformatf("post drain%0d", k), t);
        end
        step("post idle", '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});

        // ------------------------------------------------------------
        // N_CHANNELS=1, FRAME_HEIGHT=1, back-to-back frames. The upstream
        // model holds its beat until accepted; its valid never looks at ready.
        // ------------------------------------------------------------
        step2("b2b beat0",  1'b1, 16'h0077, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step2("b2b start0", 1'b1, 16'h0088, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step2("b2b word0",  1'b1, 16'h0088, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0077);
        step2("b2b beat1",  1'b1, 16'h0088, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        step2("b2b start1", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step2("b2b word1",  1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0088);
        step2("b2b idle",   1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
